// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM encoding,
// writer-stage distances, forward-select codes and the source/writer match rule.
package pipe_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam int unsigned DIST_EX  = 3;
    localparam int unsigned DIST_MEM = 2;
    localparam int unsigned DIST_WR  = 1;

    typedef enum logic [1:0] {
        FwdRf   = 2'b00,
        FwdWr   = 2'b01,
        FwdMem  = 2'b10,
        FwdRsvd = 2'b11
    } fwd_sel_e;

    // r0 is hardwired to zero, so it never creates a dependency.
    function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                     input logic regwr, input logic [4:0] rw);
        return use_src && (src != 5'd0) && regwr && (rw == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. Forwarding selects exist only
// when PIPE_FWD_EN is defined.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_rw;
    logic             ex_regwr;
    logic             ex_memtoreg;
    logic [4:0]       mem_rw;
    logic             mem_regwr;
    logic [4:0]       wr_rw;
    logic             wr_regwr;
    logic             ex_br_taken;
    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pc_load_br;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
`ifdef PIPE_FWD_EN
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
`endif

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rw, ex_regwr, ex_memtoreg,
               mem_rw, mem_regwr, wr_rw, wr_regwr, ex_br_taken,
`ifdef PIPE_FWD_EN
        input  fwd_a, fwd_b,
`endif
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_load_br,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rw, ex_regwr, ex_memtoreg,
               mem_rw, mem_regwr, wr_rw, wr_regwr, ex_br_taken,
`ifdef PIPE_FWD_EN
        output fwd_a, fwd_b,
`endif
        output pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_load_br,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_match.sv
// Combinational RAW comparator: ID sources against EX/Mem/Wr writers.
// With PIPE_FWD_EN only load-use stalls and forward selects are produced.
module hazard_match
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] ex_rw,
    input  logic       ex_regwr,
    input  logic [4:0] mem_rw,
    input  logic       mem_regwr,
    input  logic [4:0] wr_rw,
    input  logic       wr_regwr,
`ifdef PIPE_FWD_EN
    input  logic       ex_memtoreg,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
`endif
    output logic [1:0] need
);

    logic rs_ex, rs_mem, rs_wr;
    logic rt_ex, rt_mem, rt_wr;

    assign rs_ex  = src_hit(id_use_rs, id_rs, ex_regwr,  ex_rw);
    assign rs_mem = src_hit(id_use_rs, id_rs, mem_regwr, mem_rw);
    assign rs_wr  = src_hit(id_use_rs, id_rs, wr_regwr,  wr_rw);
    assign rt_ex  = src_hit(id_use_rt, id_rt, ex_regwr,  ex_rw);
    assign rt_mem = src_hit(id_use_rt, id_rt, mem_regwr, mem_rw);
    assign rt_wr  = src_hit(id_use_rt, id_rt, wr_regwr,  wr_rw);

`ifdef PIPE_FWD_EN
    // A load result is not available until after Mem, so only load-use stalls.
    assign need = ((rs_ex || rt_ex) && ex_memtoreg) ? 2'(DIST_WR) : 2'd0;

    always_comb begin
        fwd_a = FwdRf;
        fwd_b = FwdRf;
        if (rs_mem)     fwd_a = FwdMem;
        else if (rs_wr) fwd_a = FwdWr;
        if (rt_mem)     fwd_b = FwdMem;
        else if (rt_wr) fwd_b = FwdWr;
    end
`else
    // Nearest writer dominates: it needs the longest wait.
    always_comb begin
        need = 2'd0;
        if (rs_ex || rt_ex)        need = 2'(DIST_EX);
        else if (rs_mem || rt_mem) need = 2'(DIST_MEM);
        else if (rs_wr || rt_wr)   need = 2'(DIST_WR);
    end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, branch squash, perf counters.
// Optional forwarding mode selected by defining PIPE_FWD_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] FlushLoad  = 2'(FLUSH_CYCLES - 1);
    localparam bit         FlushMulti = (FLUSH_CYCLES > 1);

    state_e           state;
    logic [1:0]       cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       need;
    logic             take_br;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, pc_load_br;

    hazard_match u_match (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_use_rs   (bus.id_use_rs),
        .id_use_rt   (bus.id_use_rt),
        .ex_rw       (bus.ex_rw),
        .ex_regwr    (bus.ex_regwr),
        .mem_rw      (bus.mem_rw),
        .mem_regwr   (bus.mem_regwr),
        .wr_rw       (bus.wr_rw),
        .wr_regwr    (bus.wr_regwr),
`ifdef PIPE_FWD_EN
        .ex_memtoreg (bus.ex_memtoreg),
        .fwd_a       (bus.fwd_a),
        .fwd_b       (bus.fwd_b),
`endif
        .need        (need)
    );

`ifndef PIPE_FWD_EN
    logic unused_memtoreg;
    assign unused_memtoreg = bus.ex_memtoreg;
`endif

    // The instruction in EX during a flush is itself squashed, so its branch is ignored.
    assign take_br = bus.ex_br_taken && (state != StFlush);

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_load_br  = 1'b0;
        if (rst_n) begin
            if (take_br) begin
                pc_load_br  = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else begin
                unique case (state)
                    StRun: begin
                        pc_hold     = (need != 2'd0);
                        ifid_hold   = (need != 2'd0);
                        idex_bubble = (need != 2'd0);
                    end
                    StStall: begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    StFlush: begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StRun;
            cnt       <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (take_br) begin
                cnt   <= FlushLoad;
                state <= FlushMulti ? StFlush : StRun;
            end else begin
                unique case (state)
                    StRun: begin
                        if (need != 2'd0) begin
                            cnt   <= need - 2'd1;
                            state <= (need > 2'd1) ? StStall : StRun;
                        end
                    end
                    StStall, StFlush: begin
                        if (cnt <= 2'd1) begin
                            cnt   <= 2'd0;
                            state <= StRun;
                        end else begin
                            cnt <= cnt - 2'd1;
                        end
                    end
                    default: begin
                        cnt   <= 2'd0;
                        state <= StRun;
                    end
                endcase
            end
            if (pc_hold && (stall_cnt != '1))    stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.pc_hold     = pc_hold;
    assign bus.ifid_hold   = ifid_hold;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.pc_load_br  = pc_load_br;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage IF/ID/EX/Mem/Wr integer pipeline.
- Detects RAW hazards between the ID-stage source registers and in-flight writers, and holds the PC and IF/ID register for the required number of cycles.
- Injects bubbles into ID/EX and squashes wrong-path instructions after a taken branch resolved in EX.
- Replaces the ad-hoc stall module; drives the hold, flush and bubble enables of all pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, cycles IF/ID squash stays asserted after a taken branch (1..3).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk, in, 1, pipeline clock; all state updates on negedge clk, as for the pipeline registers.
- rst_n, in, 1, asynchronous active-low reset.
- id_rs, in, 5, ID-stage Rs field.
- id_rt, in, 5, ID-stage Rt field.
- id_use_rs, in, 1, ID instruction reads Rs.
- id_use_rt, in, 1, ID instruction reads Rt (R-type, sw, beq, bne).
- ex_rw, in, 5, EX destination (post RegDst mux).
- ex_regwr, in, 1, EX RegWr.
- ex_memtoreg, in, 1, EX instruction is lw.
- mem_rw, in, 5, Mem destination.
- mem_regwr, in, 1, Mem RegWr.
- wr_rw, in, 5, Wr destination.
- wr_regwr, in, 1, Wr RegWr.
- ex_br_taken, in, 1, branch resolved taken in EX.
- pc_hold, out, 1, PC keeps its value.
- ifid_hold, out, 1, IF/ID register keeps its value.
- ifid_flush, out, 1, IF/ID loads all-zero (nop).
- idex_bubble, out, 1, ID/EX control fields load 0.
- pc_load_br, out, 1, PC loads branch target.
- stall_cnt, out, CNT_W, saturating count of stall cycles.
- flush_cnt, out, CNT_W, saturating count of flush cycles.

Behaviour:
- Match rule: src matches a stage iff use bit=1, src!=0, stage regwr=1, stage rw==src.
- Required distance per matched stage: EX=3, Mem=2, Wr=1. need = max over all matches (0 if none).
- FSM states RUN, STALL, FLUSH. Reset state RUN, internal counter 0, both performance counters 0.
- While rst_n=0, all outputs are 0.
- RUN, ex_br_taken=1:
  - Branch wins over any hazard.
  - Same cycle (Mealy): pc_load_br=1, ifid_flush=1, idex_bubble=1.
  - Load counter=FLUSH_CYCLES-1. Go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
- RUN, need>0, no branch:
  - Same cycle: pc_hold=1, ifid_hold=1, idex_bubble=1.
  - Load counter=need-1. Go to STALL if need>1, else stay in RUN.
- STALL:
  - pc_hold=ifid_hold=idex_bubble=1.
  - Counter decrements each negedge; at 0, return to RUN (hazard re-evaluated next cycle).
  - ex_br_taken=1 in STALL cannot originate from a bubble; if asserted anyway, it aborts the stall and follows the RUN branch rule.
- FLUSH:
  - ifid_flush=1 and idex_bubble=1; no hold.
  - Counter decrements; at 0, go to RUN.
  - ex_br_taken is ignored because the EX instruction is squashed.
  - Hazards are not evaluated.
- pc_hold and pc_load_br are never both 1.
- ifid_hold and ifid_flush are never both 1.
- Counters:
  - stall_cnt increments on every cycle with pc_hold=1.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-STALL or mid-FLUSH: immediate return to RUN, counters cleared, outputs 0.

Optional Feature:
- Macro: PIPE_FWD_EN.
- Defined:
  - Only a load-use hazard stalls: EX match with ex_memtoreg=1, need=1.
  - All other matches are resolved by forwarding.
  - Adds outputs fwd_a and fwd_b, 2 bits each, combinational: 00=regfile, 01=Wr, 10=Mem, 11=reserved. The youngest matching stage wins (Mem over Wr).
- Undefined: the full interlock above applies and no forwarding ports exist.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2).
  - Stage distance constants (DIST_EX=3, DIST_MEM=2, DIST_WR=1).
  - Forward-select encodings.
- One natural sub-module: hazard_match, the combinational comparator that computes need (and the fwd selects when PIPE_FWD_EN is defined). Instantiated once.

Test Plan:
- id_rs=5, use_rs=1, ex_rw=5, ex_regwr=1 -> hold and bubble for exactly 3 cycles; stall_cnt=3.
- id_rt=7 matches mem_rw=7 and id_rs=7 matches wr_rw=7 -> 2-cycle stall (max rule); id_rs=0 with ex_rw=0 -> no stall.
- Hazard present and ex_br_taken=1 in the same cycle -> pc_load_br=1, no pc_hold, ifid_flush for 2 cycles; flush_cnt=2.
- rst_n low for 1 cycle during the 2nd cycle of a 3-cycle stall -> outputs 0 immediately; after release, state RUN and counters 0.
- Preload stall_cnt to 16'hFFFE, then hold a hazard for 5 cycles -> stall_cnt saturates at 16'hFFFF.
- PIPE_FWD_EN: EX add writes r3, ID reads r3 -> no stall, fwd_a=10 next cycle; same case with EX lw -> 1-cycle stall, then fwd_a=10.
